// File: rtl/counter_check_pkg.sv
// Shared types and constants for the counter-stream receive checker.
package counter_check_pkg;

    typedef enum logic {
        HUNT,
        LOCKED
    } check_state_e;

    localparam int unsigned MISS_W = 8;

endpackage

// File: rtl/ready_throttle.sv
// Deterministic back-pressure: in_ready drops for STALL_CYCLES after every BURST_LEN accepts.
module ready_throttle #(
    parameter int unsigned BURST_LEN    = 8,
    parameter int unsigned STALL_CYCLES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic accept,
    output logic in_ready
);

    localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned SW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'((STALL_CYCLES > 0) ? STALL_CYCLES - 1 : 0);

    logic [BW-1:0] burst_cnt;
    logic [SW-1:0] stall_cnt;

    // Burst count is cleared on stall entry so it reads 0 when in_ready returns.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            burst_cnt <= '0;
            stall_cnt <= '0;
            in_ready  <= 1'b1;
        end else if (STALL_CYCLES != 0) begin
            if (!in_ready) begin
                if (stall_cnt == STALL_LAST) begin
                    in_ready  <= 1'b1;
                    stall_cnt <= '0;
                end else begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end else if (accept) begin
                if (burst_cnt == BURST_LAST) begin
                    in_ready  <= 1'b0;
                    burst_cnt <= '0;
                end else begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/counter_stream_checker.sv
// Receive-side checker for an incrementing counter stream: lock tracking,
// saturating match/error counters and an error strobe.
module counter_stream_checker
    import counter_check_pkg::*;
#(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned RESYNC_THRESH = 4,
    parameter int unsigned BURST_LEN     = 8,
    parameter int unsigned STALL_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             clr_counts,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH-1:0] last_value
);

    localparam logic [MISS_W-1:0] THRESH_LAST = MISS_W'(RESYNC_THRESH - 1);

    check_state_e      state;
    logic [WIDTH-1:0]  expected;
    logic [MISS_W-1:0] miss_run;
    logic              accept;

    assign accept = in_valid & in_ready;
    assign locked = (state == LOCKED);

    ready_throttle #(
        .BURST_LEN    (BURST_LEN),
        .STALL_CYCLES (STALL_CYCLES)
    ) u_throttle (
        .clk      (clk),
        .reset_n  (reset_n),
        .accept   (accept),
        .in_ready (in_ready)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= HUNT;
            expected    <= '0;
            miss_run    <= '0;
            err_pulse   <= 1'b0;
            match_count <= '0;
            err_count   <= '0;
            last_value  <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (accept) begin
                expected   <= in_data + 1'b1;
                last_value <= in_data;
                case (state)
                    HUNT: begin
                        state    <= LOCKED;
                        miss_run <= '0;
                    end
                    LOCKED: begin
                        if (in_data == expected) begin
                            miss_run <= '0;
                            if (match_count != '1)
                                match_count <= match_count + 1'b1;
                        end else begin
                            err_pulse <= 1'b1;
                            if (err_count != '1)
                                err_count <= err_count + 1'b1;
                            if (miss_run == THRESH_LAST) begin
                                state    <= HUNT;
                                miss_run <= '0;
                            end else begin
                                miss_run <= miss_run + 1'b1;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
            // Placed after the increments so a clear wins on the same edge.
            if (clr_counts) begin
                match_count <= '0;
                err_count   <= '0;
            end
        end
    end

endmodule
